// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU codes, ALUOp/funct encodings and FSM state type for alu_ctrl_seq
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1000;
  localparam logic [3:0] ALU_ILL  = 4'b1001;
  localparam logic [3:0] ALU_MULT = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] OP_ORI   = 4'b0001;
  localparam logic [3:0] OP_LUI   = 4'b0010;
  localparam logic [3:0] OP_ANDI  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_RTYPE = 4'b0111;
  localparam logic [3:0] OP_BNE   = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1001;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_NOR    = 6'b100111;
  localparam logic [5:0] F_SLL    = 6'b000000;
  localparam logic [5:0] F_SRL    = 6'b000010;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_DIV    = 6'b011010;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// alu_decode: combinational ALUOp/funct to ALU code table with multi-cycle and illegal flags
module alu_decode import alu_ctrl_pkg::*; #(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4
) (
  input  logic [OP_W-1:0]    alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  code_o,
  output logic               multi_o,
  output logic               illegal_o
);
  logic [3:0] code;
  // table lookup; anything without an entry falls through to the illegal code
  always_comb begin
    code = ALU_ILL;
    if (alu_op_i == OP_W'(OP_RTYPE))
      case (funct_i)
        FUNCT_W'(F_ADD):  code = ALU_ADD;
        FUNCT_W'(F_SUB):  code = ALU_SUB;
        FUNCT_W'(F_OR):   code = ALU_OR;
        FUNCT_W'(F_AND):  code = ALU_AND;
        FUNCT_W'(F_NOR):  code = ALU_NOR;
        FUNCT_W'(F_SLL):  code = ALU_SLL;
        FUNCT_W'(F_SRL):  code = ALU_SRL;
        FUNCT_W'(F_MULT): code = ALU_MULT;
        FUNCT_W'(F_DIV):  code = ALU_DIV;
        default:          code = ALU_ILL;
      endcase
    else
      case (alu_op_i)
        OP_W'(OP_ADDI), OP_W'(OP_LW), OP_W'(OP_SW): code = ALU_ADD;
        OP_W'(OP_ORI):                              code = ALU_OR;
        OP_W'(OP_LUI):                              code = ALU_LUI;
        OP_W'(OP_ANDI):                             code = ALU_AND;
        OP_W'(OP_BEQ), OP_W'(OP_BNE):               code = ALU_SUB;
        default:                                    code = ALU_ILL;
      endcase
  end
  assign code_o    = CTRL_W'(code);
  assign multi_o   = (code == ALU_MULT) || (code == ALU_DIV);
  assign illegal_o = code == ALU_ILL;
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with multi-cycle MULT/DIV sequencing
module alu_ctrl_seq import alu_ctrl_pkg::*; #(
  parameter int OP_W        = 4,
  parameter int FUNCT_W     = 6,
  parameter int CTRL_W      = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    alu_op_i,
  input  logic [FUNCT_W-1:0] alu_function_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic [CTRL_W-1:0]  alu_operation_o,
  output logic               op_valid_o,
  output logic               stall_o,
  output logic               multi_done_o,
  output logic               illegal_o
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CTRL_W-1:0] alu_operation_q, alu_operation_d, dec_code;
  logic op_valid_q, op_valid_d, stall_q, stall_d, multi_done_q, multi_done_d;
  logic illegal_q, illegal_d, dec_multi, dec_illegal, accept;
  alu_decode #(.OP_W(OP_W), .FUNCT_W(FUNCT_W), .CTRL_W(CTRL_W)) u_decode (
    .alu_op_i  (alu_op_i),
    .funct_i   (alu_function_i),
    .code_o    (dec_code),
    .multi_o   (dec_multi),
    .illegal_o (dec_illegal)
  );
  assign ready_o = state_q != ST_BUSY;
  assign accept  = valid_i && ready_o && !flush_i;
  // next state: flush wins, BUSY counts down to DONE, otherwise accept or fall back to IDLE
  always_comb begin
    state_d         = ST_IDLE;
    cnt_d           = cnt_q;
    alu_operation_d = alu_operation_q;
    op_valid_d      = 1'b0;
    multi_done_d    = 1'b0;
    illegal_d       = 1'b0;
    if (flush_i) begin
      cnt_d = '0;
    end else if (state_q == ST_BUSY) begin
      state_d      = cnt_q == '0 ? ST_DONE : ST_BUSY;
      cnt_d        = cnt_q == '0 ? '0 : cnt_q - CNT_W'(1);
      op_valid_d   = cnt_q == '0;
      multi_done_d = cnt_q == '0;
    end else if (accept) begin
      state_d         = dec_multi ? ST_BUSY : ST_IDLE;
      cnt_d           = !dec_multi ? '0 : dec_code == CTRL_W'(ALU_DIV) ? DIV_LOAD : MULT_LOAD;
      alu_operation_d = dec_code;
      op_valid_d      = !dec_multi;
      illegal_d       = dec_illegal;
    end
    stall_d = state_d == ST_BUSY;
  end
  // state and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      alu_operation_q <= '0;
      op_valid_q      <= 1'b0;
      stall_q         <= 1'b0;
      multi_done_q    <= 1'b0;
      illegal_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      alu_operation_q <= alu_operation_d;
      op_valid_q      <= op_valid_d;
      stall_q         <= stall_d;
      multi_done_q    <= multi_done_d;
      illegal_q       <= illegal_d;
    end
  end
  assign alu_operation_o = alu_operation_q;
  assign op_valid_o      = op_valid_q;
  assign stall_o         = stall_q;
  assign multi_done_o    = multi_done_q;
  assign illegal_o       = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: vector table, corner sequences and randomized model check for alu_ctrl_seq
module tb_alu_ctrl_seq;
  logic clk = 1'b0, reset = 1'b0, valid_i = 1'b0, flush_i = 1'b0;
  logic [3:0] alu_op_i = '0;
  logic [5:0] alu_function_i = '0;
  logic ready_o, op_valid_o, stall_o, multi_done_o, illegal_o;
  logic [3:0] alu_operation_o;
  int n_pass = 0, n_tot = 0;
  logic [5:0] fn_tab [9] = '{6'h20, 6'h22, 6'h25, 6'h24, 6'h27, 6'h00, 6'h02, 6'h18, 6'h1A};
  logic [3:0] fn_code [9] = '{4'h3, 4'h4, 4'h1, 4'h7, 4'h8, 4'h2, 4'h5, 4'hA, 4'hB};
  logic [3:0] op_code [16] = '{4'h9, 4'h1, 4'h6, 4'h7, 4'h3, 4'h3, 4'h4, 4'h9,
                               4'h4, 4'h3, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
  typedef struct {logic [3:0] op; logic [5:0] f; logic [3:0] code; logic ill;} vec_t;
  vec_t tbl[$];
  int m_rem;
  logic [3:0] m_code;
  logic m_ov, m_done, m_ill, seen;

  alu_ctrl_seq dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .alu_op_i(alu_op_i),
    .alu_function_i(alu_function_i), .flush_i(flush_i), .ready_o(ready_o),
    .alu_operation_o(alu_operation_o), .op_valid_o(op_valid_o), .stall_o(stall_o),
    .multi_done_o(multi_done_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {ready_o, stall_o, multi_done_o, op_valid_o, illegal_o, alu_operation_o};
  endfunction

  function automatic logic [3:0] ref_code(input logic [3:0] op, input logic [5:0] f);
    if (op != 4'h7) return op_code[op];
    for (int i = 0; i < 9; i++) if (fn_tab[i] == f) return fn_code[i];
    return 4'h9;
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got rdy/stl/done/ov/ill/op=%b expected %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f, input logic fl);
    valid_i = v;
    alu_op_i = op;
    alu_function_i = f;
    flush_i = fl;
  endtask

  // cycle-count reference: m_rem is the number of stall cycles still to run
  task automatic model_step();
    logic [3:0] c;
    if (flush_i) begin
      m_rem = 0; m_ov = 0; m_done = 0; m_ill = 0;
    end else if (m_rem > 0) begin
      m_rem--; m_ov = m_rem == 0; m_done = m_rem == 0; m_ill = 0;
    end else if (valid_i) begin
      c = ref_code(alu_op_i, alu_function_i);
      m_code = c; m_ill = c == 4'h9; m_done = 0;
      m_rem = c == 4'hA ? 4 : c == 4'hB ? 32 : 0;
      m_ov = m_rem == 0;
    end else begin
      m_ov = 0; m_done = 0; m_ill = 0;
    end
  endtask

  initial begin
    tbl.push_back('{4'h7, 6'h20, 4'h3, 1'b0});
    tbl.push_back('{4'h7, 6'h22, 4'h4, 1'b0});
    tbl.push_back('{4'h7, 6'h25, 4'h1, 1'b0});
    tbl.push_back('{4'h7, 6'h24, 4'h7, 1'b0});
    tbl.push_back('{4'h7, 6'h27, 4'h8, 1'b0});
    tbl.push_back('{4'h7, 6'h00, 4'h2, 1'b0});
    tbl.push_back('{4'h7, 6'h02, 4'h5, 1'b0});
    tbl.push_back('{4'h4, 6'h3F, 4'h3, 1'b0});
    tbl.push_back('{4'h5, 6'h22, 4'h3, 1'b0});
    tbl.push_back('{4'h9, 6'h00, 4'h3, 1'b0});
    tbl.push_back('{4'h1, 6'h20, 4'h1, 1'b0});
    tbl.push_back('{4'h2, 6'h11, 4'h6, 1'b0});
    tbl.push_back('{4'h3, 6'h18, 4'h7, 1'b0});
    tbl.push_back('{4'h6, 6'h1A, 4'h4, 1'b0});
    tbl.push_back('{4'h8, 6'h05, 4'h4, 1'b0});
    tbl.push_back('{4'hF, 6'h20, 4'h9, 1'b1});
    tbl.push_back('{4'h0, 6'h20, 4'h9, 1'b1});
    tbl.push_back('{4'h7, 6'h3F, 4'h9, 1'b1});
    tbl.push_back('{4'h7, 6'h01, 4'h9, 1'b1});

    #1 chk("reset_hold", obs() & 9'h0FF, 9'h000);
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    tick();
    chk("reset_release", obs(), 9'h100);

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].op, tbl[i].f, 1'b0);
      tick();
      chk($sformatf("tbl%0d", i), obs(), {4'b1001, tbl[i].ill, tbl[i].code});
    end
    drive(1'b0, 4'h7, 6'h22, 1'b0);
    tick();
    chk("single_pulse", obs(), {5'b10000, 4'h9});

    drive(1'b1, 4'h7, 6'h18, 1'b0);
    tick();
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    chk("mult_busy1", obs(), {5'b01000, 4'hA});
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("mult_busy%0d", i), obs(), {5'b01000, 4'hA});
    end
    tick();
    chk("mult_done", obs(), {5'b10110, 4'hA});
    drive(1'b1, 4'h4, 6'h00, 1'b0);
    tick();
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    chk("addi_after_done", obs(), {5'b10010, 4'h3});
    tick();
    chk("addi_pulse_end", obs(), {5'b10000, 4'h3});

    drive(1'b1, 4'h7, 6'h1A, 1'b0);
    tick();
    drive(1'b1, 4'h4, 6'h00, 1'b0);
    chk("div_busy1", obs(), {5'b01000, 4'hB});
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("div_busy%0d", i), obs(), {5'b01000, 4'hB});
    end
    drive(1'b0, 4'h0, 6'h00, 1'b1);
    tick();
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    chk("div_flush", obs() & 9'h1E0, 9'h100);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= multi_done_o | stall_o;
    end
    chk("div_flush_quiet", {8'h0, seen}, 9'h000);

    drive(1'b1, 4'h7, 6'h1A, 1'b0);
    tick();
    drive(1'b0, 4'h0, 6'h00, 1'b0);
    tick(); tick();
    chk("div_pre_reset", obs(), {5'b01000, 4'hB});
    #1 reset = 1'b0;
    #1 chk("div_async_reset", obs() & 9'h0FF, 9'h000);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("div_reset_release", obs(), 9'h100);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= multi_done_o;
    end
    chk("div_reset_nodone", {8'h0, seen}, 9'h000);

    #1 reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    m_rem = 0; m_code = 4'h0; m_ov = 0; m_done = 0; m_ill = 0;
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1 ? 4'h7 : 4'($urandom),
            $urandom_range(0, 3) == 0 ? 6'($urandom) : fn_tab[$urandom_range(0, 8)],
            $urandom_range(0, 15) == 0);
      model_step();
      tick();
      chk("rand", obs(), {m_rem == 0, m_rem > 0, m_done, m_ov, m_ill, m_code});
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
